fproc_meas: RTL and testbench

FPROC_MEAS -- requirements
Module: fproc_meas

---
 rtl/fproc_pkg.sv | 18 +
 rtl/fproc_meas_latch.sv | 35 +++
 rtl/fproc_meas.sv | 174 +++++++++++++++++
 tb/tb_fproc_meas.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fproc_pkg.sv
// Shared types and constants for the fproc measurement responder.
package fproc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_t;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ID_WIDTH       = 8;
  localparam int DEF_NUM_MEAS       = 8;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Every bit of a timed-out response word carries this value.
  localparam logic TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/fproc_meas_latch.sv
// One measurement channel: latest result bit plus an unread (fresh) flag.
module meas_latch (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  input  logic i_bit,
  input  logic i_clr,
  output logic o_result,
  output logic o_fresh,
  output logic o_ovr_evt
);

  logic r_result;
  logic r_fresh;

  // A new result always wins over a read-clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= 1'b0;
      r_fresh  <= 1'b0;
    end else if (i_valid) begin
      r_result <= i_bit;
      r_fresh  <= 1'b1;
    end else if (i_clr) begin
      r_fresh  <= 1'b0;
    end else begin
      r_fresh  <= r_fresh;
    end
  end

  assign o_result  = r_result;
  assign o_fresh   = r_fresh;
  assign o_ovr_evt = i_valid & r_fresh & ~i_clr;

endmodule

// File: rtl/fproc_meas.sv
// Answers processor requests for the latest measurement bit of a channel.
// Optional wait timeout is enabled by defining FPROC_MEAS_TIMEOUT_EN.
module fproc_meas
  import fproc_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ID_WIDTH       = DEF_ID_WIDTH,
  parameter int NUM_MEAS       = DEF_NUM_MEAS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_MEAS-1:0]   meas_valid,
  input  logic [NUM_MEAS-1:0]   meas_bit,
  input  logic                  fproc_en,
  input  logic [ID_WIDTH-1:0]   fproc_id,
  output logic                  fproc_ready,
  output logic [DATA_WIDTH-1:0] fproc_data,
  output logic                  busy,
  output logic                  overrun
);

  if (NUM_MEAS < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("fproc_meas: parameter out of range");
  end

  fsm_state_t            r_state;
  fsm_state_t            w_state_nxt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ID_WIDTH-1:0]   w_id_nxt;
  logic                  r_id_ok;
  logic                  w_id_ok_nxt;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_ovr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;

  logic [NUM_MEAS-1:0]   w_result;
  logic [NUM_MEAS-1:0]   w_fresh;
  logic [NUM_MEAS-1:0]   w_clr;
  logic [NUM_MEAS-1:0]   w_ovr_vec;

  logic [ID_WIDTH-1:0]   w_sel_id;
  logic                  w_sel_valid;
  logic                  w_sel_bit;
  logic                  w_sel_fresh;
  logic                  w_sel_res;
  logic                  w_req_ok;

  for (genvar gi = 0; gi < NUM_MEAS; gi++) begin : g_ch
    assign w_clr[gi] = (r_state == ST_RESP) && r_id_ok && (r_id == ID_WIDTH'(gi));

    meas_latch u_latch (
      .clk       (clk),
      .reset     (reset),
      .i_valid   (meas_valid[gi]),
      .i_bit     (meas_bit[gi]),
      .i_clr     (w_clr[gi]),
      .o_result  (w_result[gi]),
      .o_fresh   (w_fresh[gi]),
      .o_ovr_evt (w_ovr_vec[gi])
    );
  end

  // In IDLE the incoming id is looked up; otherwise the latched one.
  always_comb begin
    w_sel_id    = (r_state == ST_IDLE) ? fproc_id : r_id;
    w_sel_valid = 1'b0;
    w_sel_bit   = 1'b0;
    w_sel_fresh = 1'b0;
    w_sel_res   = 1'b0;
    for (int i = 0; i < NUM_MEAS; i++) begin
      w_sel_valid = w_sel_valid | ((ID_WIDTH'(i) == w_sel_id) & meas_valid[i]);
      w_sel_bit   = w_sel_bit   | ((ID_WIDTH'(i) == w_sel_id) & meas_bit[i]);
      w_sel_fresh = w_sel_fresh | ((ID_WIDTH'(i) == w_sel_id) & w_fresh[i]);
      w_sel_res   = w_sel_res   | ((ID_WIDTH'(i) == w_sel_id) & w_result[i]);
    end
    w_req_ok = (32'(fproc_id) < 32'(NUM_MEAS));
  end

`ifdef FPROC_MEAS_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        w_timeout;

  // Counter sits at zero outside WAIT, so it starts fresh on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 16'd0;
    end else if (r_state != ST_WAIT) begin
      r_wait_cnt <= 16'd0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and response word; data is nonzero only when entering RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_id_ok_nxt = r_id_ok;
    w_data_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (fproc_en) begin
          w_id_nxt    = fproc_id;
          w_id_ok_nxt = w_req_ok;
          if (!w_req_ok) begin
            w_state_nxt = ST_RESP;
          end else if (w_sel_valid) begin
            w_state_nxt = ST_RESP;
            w_data_nxt  = DATA_WIDTH'(w_sel_bit);
          end else if (w_sel_fresh) begin
            w_state_nxt = ST_RESP;
            w_data_nxt  = DATA_WIDTH'(w_sel_res);
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (w_sel_valid) begin
          w_state_nxt = ST_RESP;
          w_data_nxt  = DATA_WIDTH'(w_sel_bit);
`ifdef FPROC_MEAS_TIMEOUT_EN
        end else if (w_timeout) begin
          w_state_nxt = ST_RESP;
          w_data_nxt  = {DATA_WIDTH{TIMEOUT_FILL}};
`endif
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_id_ok <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      r_id_ok <= w_id_ok_nxt;
      r_ready <= (w_state_nxt == ST_RESP);
      r_data  <= w_data_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ovr   <= r_ovr | (|w_ovr_vec);
    end
  end

  assign fproc_ready = r_ready;
  assign fproc_data  = r_data;
  assign busy        = r_busy;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_fproc_meas.sv
// Randomized bench for fproc_meas against a per-cycle transaction model.
// Define FPROC_MEAS_TIMEOUT_EN to also exercise the wait timeout.
module tb_fproc_meas;

  localparam int DW = 32;
  localparam int IW = 8;
  localparam int NM = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] meas_valid;
  logic [NM-1:0] meas_bit;
  logic          fproc_en;
  logic [IW-1:0] fproc_id;
  logic          fproc_ready;
  logic [DW-1:0] fproc_data;
  logic          busy;
  logic          overrun;

  fproc_meas #(
    .DATA_WIDTH     (DW),
    .ID_WIDTH       (IW),
    .NUM_MEAS       (NM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .meas_valid  (meas_valid),
    .meas_bit    (meas_bit),
    .fproc_en    (fproc_en),
    .fproc_id    (fproc_id),
    .fproc_ready (fproc_ready),
    .fproc_data  (fproc_data),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: channel contents, an outstanding request and its age.
  bit            m_res   [NM];
  bit            m_fresh [NM];
  bit            m_ovr;
  bit            m_pending;
  bit            m_responding;
  int            m_id;
  int            m_waited;
  logic [DW-1:0] m_data;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NM; i++) begin
      m_res[i]   = 1'b0;
      m_fresh[i] = 1'b0;
    end
    m_ovr        = 1'b0;
    m_pending    = 1'b0;
    m_responding = 1'b0;
    m_id         = 0;
    m_waited     = 0;
    m_data       = '0;
  endfunction

  function automatic void model_step(input logic [NM-1:0] mv, input logic [NM-1:0] mb,
                                     input bit en, input int id);
    int clr_ch;
    bit answer;
    logic [DW-1:0] ans_data;
    clr_ch   = (m_responding && m_id < NM) ? m_id : -1;
    answer   = 1'b0;
    ans_data = '0;
    if (m_responding) begin
      m_responding = 1'b0;
    end else if (m_pending) begin
      if (mv[m_id]) begin
        answer   = 1'b1;
        ans_data = DW'(mb[m_id]);
      end else begin
        m_waited++;
`ifdef FPROC_MEAS_TIMEOUT_EN
        if (m_waited == TO) begin
          answer   = 1'b1;
          ans_data = '1;
        end
`endif
      end
    end else if (en) begin
      m_id = id;
      if (id >= NM) begin
        answer = 1'b1;
      end else if (mv[id]) begin
        answer   = 1'b1;
        ans_data = DW'(mb[id]);
      end else if (m_fresh[id]) begin
        answer   = 1'b1;
        ans_data = DW'(m_res[id]);
      end else begin
        m_pending = 1'b1;
        m_waited  = 0;
      end
    end
    if (answer) begin
      m_pending    = 1'b0;
      m_responding = 1'b1;
    end
    m_data = ans_data;
    for (int i = 0; i < NM; i++) begin
      if (mv[i] && m_fresh[i] && i != clr_ch) m_ovr = 1'b1;
      if (mv[i]) begin
        m_res[i]   = mb[i];
        m_fresh[i] = 1'b1;
      end else if (i == clr_ch) begin
        m_fresh[i] = 1'b0;
      end
    end
  endfunction

  task automatic cycle(input logic [NM-1:0] mv, input logic [NM-1:0] mb,
                       input bit en, input int id);
    meas_valid = mv;
    meas_bit   = mb;
    fproc_en   = en;
    fproc_id   = IW'(id);
    model_step(mv, mb, en, id);
    @(posedge clk);
    #1;
    chk_eq("ready", {63'd0, fproc_ready}, {63'd0, m_responding});
    chk_eq("data", {32'd0, fproc_data}, {32'd0, m_data});
    chk_eq("busy", {63'd0, busy}, {63'd0, (m_pending | m_responding)});
    chk_eq("overrun", {63'd0, overrun}, {63'd0, m_ovr});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0, 1'b0, 0);
  endtask

  initial begin
    reset      = 1'b1;
    meas_valid = '0;
    meas_bit   = '0;
    fproc_en   = 1'b0;
    fproc_id   = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk_eq("rst_ready", {63'd0, fproc_ready}, 64'd0);
    chk_eq("rst_data", {32'd0, fproc_data}, 64'd0);
    chk_eq("rst_busy", {63'd0, busy}, 64'd0);
    chk_eq("rst_overrun", {63'd0, overrun}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Hit on a stored result, then a repeat read of the same channel misses.
    cycle(8'h04, 8'h04, 1'b0, 0);
    idle(2);
    cycle(8'h00, 8'h00, 1'b1, 2);
    chk_eq("hit_data", {32'd0, fproc_data}, 64'd1);
    idle(1);
    cycle(8'h00, 8'h00, 1'b1, 2);
    chk_eq("reread_busy", {63'd0, busy}, 64'd1);
    idle(2);
    cycle(8'h04, 8'h00, 1'b0, 0);
    idle(2);

    // Miss: answer arrives ten cycles after the request.
    cycle(8'h00, 8'h00, 1'b1, 5);
    idle(9);
    cycle(8'h20, 8'h00, 1'b0, 0);
    chk_eq("miss_ready", {63'd0, fproc_ready}, 64'd1);
    idle(2);

    // Request and result for the same channel in the same cycle.
    cycle(8'h02, 8'h02, 1'b1, 1);
    chk_eq("simul_data", {32'd0, fproc_data}, 64'd1);
    chk_eq("simul_ovr", {63'd0, overrun}, 64'd0);
    idle(2);

    // Two unread results on channel 0, then an out-of-range id.
    cycle(8'h01, 8'h01, 1'b0, 0);
    cycle(8'h01, 8'h00, 1'b0, 0);
    chk_eq("ovr_set", {63'd0, overrun}, 64'd1);
    cycle(8'h00, 8'h00, 1'b1, 200);
    chk_eq("range_data", {32'd0, fproc_data}, 64'd0);
    idle(2);
    cycle(8'h00, 8'h00, 1'b1, 0);
    chk_eq("latest_kept", {32'd0, fproc_data}, 64'd0);
    idle(2);

    // Reset while waiting discards the request.
    cycle(8'h00, 8'h00, 1'b1, 3);
    idle(2);
    reset = 1'b1;
    #1;
    chk_eq("async_busy", {63'd0, busy}, 64'd0);
    chk_eq("async_ovr", {63'd0, overrun}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle(4);

`ifdef FPROC_MEAS_TIMEOUT_EN
    cycle(8'h00, 8'h00, 1'b1, 4);
    idle(TO);
    chk_eq("timeout_data", {32'd0, fproc_data}, 64'h0000_0000_FFFF_FFFF);
    idle(2);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [NM-1:0] mv;
      logic [NM-1:0] mb;
      bit en;
      int id;
      mv = NM'($urandom & $urandom & $urandom);
      mb = NM'($urandom);
      en = ($urandom_range(0, 3) == 0);
      id = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, NM - 1));
      cycle(mv, mb, en, id);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
